// File: rtl/instr_mem_responder.sv
// Instruction-fetch memory responder: fixed LATENCY-cycle read pipeline into an in-order answer FIFO.
// Backpressure: a credit counter caps outstanding requests at OUT_DEPTH, so the FIFO can never overflow.
package instr_mem_pkg;
    localparam int XLEN  = 64;
    localparam int TAG_W = 4;

    localparam logic [1:0] MEM_ACC_INSTR = 2'd0;
    localparam logic [1:0] MEM_ACC_LD    = 2'd1;
    localparam logic [1:0] MEM_ACC_ST    = 2'd2;

    localparam logic [4:0] E_I_ADDR_MISALIGNED = 5'd0;
    localparam logic [4:0] E_I_ACCESS_FAULT    = 5'd1;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [1:0]       acc_type;
        logic [2:0]       ls_type;
        logic [XLEN-1:0]  addr;
        logic [XLEN-1:0]  value;
    } mem_req_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [1:0]       acc_type;
        logic [XLEN-1:0]  value;
        logic             except_raised;
        logic [4:0]       except_code;
    } mem_ans_t;
endpackage

module instr_mem_responder
    import instr_mem_pkg::*;
#(
    parameter int unsigned     MEM_WORDS = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR = 64'h0,
    parameter int unsigned     LATENCY   = 2,
    parameter int unsigned     OUT_DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         flush_i,
    input  logic                         mem_valid_i,
    output logic                         mem_ready_o,
    input  mem_req_t                     mem_req_i,
    output logic                         mem_valid_o,
    input  logic                         mem_ready_i,
    output mem_ans_t                     mem_ans_o,
    input  logic                         init_we_i,
    input  logic [$clog2(MEM_WORDS)-1:0] init_addr_i,
    input  logic [31:0]                  init_data_i
);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);
    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam logic [XLEN-1:0] MEM_BYTES = XLEN'(MEM_WORDS) << 2;

    logic [31:0] mem_q [MEM_WORDS];

    always_ff @(posedge clk_i) begin
        if (init_we_i) begin
            mem_q[init_addr_i] <= init_data_i;
        end
    end

    logic             req_hs;
    logic             ans_hs;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN:0]    dec_diff;
    logic [XLEN-1:0]  dec_off;
    logic             dec_below;
    logic [IDX_W-1:0] dec_idx;
    mem_ans_t         dec_ans;
    logic             unused_req_bits;

    assign unused_req_bits = ^{mem_req_i.ls_type, mem_req_i.value};

    assign mem_ready_o = (cnt_q < CNT_W'(OUT_DEPTH)) && !flush_i;
    assign req_hs      = mem_valid_i && mem_ready_o;
    assign ans_hs      = mem_valid_o && mem_ready_i;

    // Extra borrow bit keeps addresses below BASE_ADDR from wrapping into range.
    always_comb begin
        dec_diff  = {1'b0, mem_req_i.addr} - {1'b0, BASE_ADDR};
        dec_below = dec_diff[XLEN];
        dec_off   = dec_diff[XLEN-1:0];
        dec_idx   = dec_off[IDX_W+1:2];
        dec_ans          = '0;
        dec_ans.tag      = mem_req_i.tag;
        dec_ans.acc_type = mem_req_i.acc_type;
        if (mem_req_i.acc_type != MEM_ACC_INSTR) begin
            dec_ans.except_raised = 1'b1;
            dec_ans.except_code   = E_I_ACCESS_FAULT;
        end else if (mem_req_i.addr[1:0] != 2'b00) begin
            dec_ans.except_raised = 1'b1;
            dec_ans.except_code   = E_I_ADDR_MISALIGNED;
        end else if (dec_below || (dec_off >= MEM_BYTES)) begin
            dec_ans.except_raised = 1'b1;
            dec_ans.except_code   = E_I_ACCESS_FAULT;
        end else begin
            dec_ans.value = {{(XLEN-32){1'b0}}, mem_q[dec_idx]};
        end
    end

    logic     tail_vld;
    mem_ans_t tail_ans;

    // The array read is registered by the first pipeline stage (or the FIFO when LATENCY is 1).
    if (LATENCY > 1) begin : g_pipe
        localparam int NS = LATENCY - 1;
        logic [NS-1:0] vld_q, vld_d;
        mem_ans_t      ans_q [NS];
        mem_ans_t      ans_d [NS];

        always_comb begin
            vld_d[0] = req_hs;
            ans_d[0] = dec_ans;
            for (int i = 1; i < NS; i++) begin
                vld_d[i] = vld_q[i-1];
                ans_d[i] = ans_q[i-1];
            end
            if (flush_i) begin
                vld_d = '0;
            end
        end

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                vld_q <= '0;
                for (int i = 0; i < NS; i++) begin
                    ans_q[i] <= '0;
                end
            end else begin
                vld_q <= vld_d;
                ans_q <= ans_d;
            end
        end

        assign tail_vld = vld_q[NS-1];
        assign tail_ans = ans_q[NS-1];
    end else begin : g_nopipe
        assign tail_vld = req_hs;
        assign tail_ans = dec_ans;
    end

    mem_ans_t         fifo_q [OUT_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] fill_q, fill_d;
    logic             push;
    logic             fifo_full;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign push      = tail_vld && !flush_i;
    assign fifo_full = (fill_q == CNT_W'(OUT_DEPTH));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (ans_hs) rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push, ans_hs})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase
        case ({req_hs, ans_hs})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= tail_ans;
        end
    end

    assign mem_valid_o = (fill_q != '0);
    assign mem_ans_o   = mem_valid_o ? fifo_q[rd_ptr_q] : '0;

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i) !(push && fifo_full));

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed and randomized bench for instr_mem_responder with a queue-based answer model.
module tb_instr_mem_responder;
    import instr_mem_pkg::*;

    localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
    localparam int          WORDS = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush;
    logic        req_vld, req_rdy, ans_vld, ans_rdy;
    mem_req_t    req;
    mem_ans_t    ans;
    logic        d1_req_vld, d1_req_rdy, d1_ans_vld, d1_ans_rdy;
    mem_req_t    d1_req;
    mem_ans_t    d1_ans;
    logic        init_we;
    logic [9:0]  init_addr;
    logic [31:0] init_data;

    instr_mem_responder #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE), .LATENCY(2), .OUT_DEPTH(2)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
        .mem_valid_i(req_vld), .mem_ready_o(req_rdy), .mem_req_i(req),
        .mem_valid_o(ans_vld), .mem_ready_i(ans_rdy), .mem_ans_o(ans),
        .init_we_i(init_we), .init_addr_i(init_addr), .init_data_i(init_data)
    );

    instr_mem_responder #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE), .LATENCY(1), .OUT_DEPTH(2)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
        .mem_valid_i(d1_req_vld), .mem_ready_o(d1_req_rdy), .mem_req_i(d1_req),
        .mem_valid_o(d1_ans_vld), .mem_ready_i(d1_ans_rdy), .mem_ans_o(d1_ans),
        .init_we_i(init_we), .init_addr_i(init_addr), .init_data_i(init_data)
    );

    int          checks = 0;
    int          errors = 0;
    int          n_ans  = 0;
    logic [31:0] model_mem [WORDS];
    mem_ans_t    exp_q [$];
    logic        prev_hold = 1'b0;
    mem_ans_t    prev_ans;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference answer straight from the access rules.
    function automatic mem_ans_t model(input mem_req_t r);
        mem_ans_t a;
        a = '0;
        a.tag      = r.tag;
        a.acc_type = r.acc_type;
        if (r.acc_type != MEM_ACC_INSTR) begin
            a.except_raised = 1'b1; a.except_code = E_I_ACCESS_FAULT;
        end else if ((r.addr % 4) != 0) begin
            a.except_raised = 1'b1; a.except_code = E_I_ADDR_MISALIGNED;
        end else if (r.addr < BASE || r.addr >= BASE + 4 * WORDS) begin
            a.except_raised = 1'b1; a.except_code = E_I_ACCESS_FAULT;
        end else begin
            a.value = 64'(model_mem[int'((r.addr - BASE) / 4)]);
        end
        return a;
    endfunction

    function automatic mem_req_t mk(input logic [3:0] tag, input logic [1:0] acc, input logic [63:0] addr);
        mem_req_t r;
        r.tag = tag; r.acc_type = acc; r.addr = addr;
        r.ls_type = 3'($urandom);
        r.value   = {$urandom, $urandom};
        return r;
    endfunction

    function automatic mem_req_t rand_req();
        logic [63:0] a;
        case ($urandom_range(0, 9))
            0:       a = BASE + 64'($urandom_range(0, 1023)) * 4 + 64'($urandom_range(1, 3));
            1:       a = BASE - 64'($urandom_range(1, 64)) * 4;
            2:       a = BASE + 64'd4096 + 64'($urandom_range(0, 63)) * 4;
            default: a = BASE + 64'($urandom_range(0, 1023)) * 4;
        endcase
        return mk(4'($urandom), ($urandom_range(0, 9) == 0) ? MEM_ACC_LD : MEM_ACC_INSTR, a);
    endfunction

    // Scoreboard for the LATENCY=2 instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) chk("ans_stable", {ans_vld, ans}, {1'b1, prev_ans});
            if (ans_vld && ans_rdy) begin
                n_ans++;
                if (exp_q.size() == 0) chk("spurious_ans", exp_q.size(), 1);
                else chk("ans_order", ans, exp_q.pop_front());
            end
            if (req_vld && req_rdy) exp_q.push_back(model(req));
            if (flush) exp_q.delete();
            prev_hold = ans_vld && !ans_rdy && !flush;
            prev_ans  = ans;
        end
    end

    task automatic write_word(input int i, input logic [31:0] d);
        init_we = 1'b1; init_addr = 10'(i); init_data = d;
        @(posedge clk); #1;
        init_we = 1'b0;
        model_mem[i] = d;
    endtask

    task automatic send_one(input logic [3:0] tag, input logic [1:0] acc, input logic [63:0] addr,
                            output mem_ans_t got);
        int n;
        req_vld = 1'b1; req = mk(tag, acc, addr); ans_rdy = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_rdy && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_vld = 1'b0;
        n = 0;
        @(negedge clk);
        while (!ans_vld && n < 20) begin @(negedge clk); n++; end
        chk("send_timeout", n < 20, 1'b1);
        got = ans;
        @(posedge clk); #1;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_ans_t    got;
        int          n, acc, ans0;
        logic [31:0] pre [4];
        mem_req_t    d1_reqs [11];
        pre = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00300193};

        rst_n = 0; flush = 0; req_vld = 0; req = '0; ans_rdy = 0;
        d1_req_vld = 0; d1_req = '0; d1_ans_rdy = 0;
        init_we = 0; init_addr = '0; init_data = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("reset_valid", ans_vld, 1'b0);
        chk("reset_ans", ans, '0);
        chk("reset_ready", req_rdy, 1'b1);
        chk("reset_d1_valid", d1_ans_vld, 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i < WORDS; i++) write_word(i, (i < 4) ? pre[i] : $urandom);

        // In-order answers and exact first-answer latency.
        ans_rdy = 1; req_vld = 1; req = mk(4'd0, MEM_ACC_INSTR, BASE);
        @(negedge clk); chk("lat_ready", req_rdy, 1'b1);
        @(posedge clk); #1; req = mk(4'd1, MEM_ACC_INSTR, BASE + 4);
        @(negedge clk); chk("lat_t1_empty", ans_vld, 1'b0);
        @(posedge clk); #1; req_vld = 0;
        @(negedge clk);
        chk("lat_t2_valid", ans_vld, 1'b1);
        chk("lat_t2_value", ans.value, 64'h13);
        chk("lat_t2_tag", ans.tag, 4'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat_2nd_value", ans.value, 64'h00100093);
        chk("lat_2nd_tag", ans.tag, 4'd1);
        repeat (3) @(posedge clk); #1;

        // Backpressure: only two requests outstanding.
        ans_rdy = 0; acc = 0; ans0 = n_ans;
        req_vld = 1; req = mk(4'd2, MEM_ACC_INSTR, BASE);
        repeat (6) begin
            @(negedge clk); if (req_rdy) acc++;
            @(posedge clk); #1; req = mk(4'(2 + acc), MEM_ACC_INSTR, BASE + 64'(4 * acc));
        end
        chk("bp_accepted", acc, 2);
        @(negedge clk);
        chk("bp_ready_low", req_rdy, 1'b0);
        chk("bp_head", ans.value, 64'h13);
        @(posedge clk); #1; ans_rdy = 1;
        n = 0;
        while (acc < 3 && n < 20) begin
            @(negedge clk); if (req_rdy) acc++;
            @(posedge clk); #1; n++;
        end
        req_vld = 0;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin @(posedge clk); #1; n++; end
        chk("bp_third", acc, 3);
        chk("bp_answer_count", n_ans - ans0, 3);

        // Exceptions.
        send_one(4'd3, MEM_ACC_INSTR, BASE + 2, got);
        chk("mis_code", {got.except_raised, got.except_code, got.value}, {1'b1, E_I_ADDR_MISALIGNED, 64'h0});
        send_one(4'd4, MEM_ACC_INSTR, BASE + 4096, got);
        chk("oor_code", {got.except_raised, got.except_code, got.value}, {1'b1, E_I_ACCESS_FAULT, 64'h0});
        send_one(4'd5, MEM_ACC_LD, BASE + 8, got);
        chk("ld_code", {got.except_raised, got.except_code, got.value}, {1'b1, E_I_ACCESS_FAULT, 64'h0});
        chk("ld_acc_echo", got.acc_type, MEM_ACC_LD);
        send_one(4'd6, MEM_ACC_INSTR, BASE - 4, got);
        chk("below_code", {got.except_raised, got.except_code}, {1'b1, E_I_ACCESS_FAULT});

        // Flush with two outstanding.
        ans_rdy = 0; req_vld = 1; req = mk(4'd1, MEM_ACC_INSTR, BASE);
        @(negedge clk); chk("fl_acc0", req_rdy, 1'b1);
        @(posedge clk); #1; req = mk(4'd2, MEM_ACC_INSTR, BASE + 4);
        @(negedge clk); chk("fl_acc1", req_rdy, 1'b1);
        @(posedge clk); #1; req = mk(4'd3, MEM_ACC_INSTR, BASE + 8); flush = 1;
        @(negedge clk); chk("fl_ready_during", req_rdy, 1'b0);
        @(posedge clk); #1; flush = 0; req_vld = 0; ans_rdy = 1;
        @(negedge clk);
        chk("fl_valid_after", ans_vld, 1'b0);
        chk("fl_ready_after", req_rdy, 1'b1);
        @(posedge clk); #1; req_vld = 1; flush = 1;
        @(negedge clk); chk("fl_gate_idle", req_rdy, 1'b0);
        @(posedge clk); #1; flush = 0; req_vld = 0;
        repeat (5) begin @(negedge clk); chk("fl_no_stale", ans_vld, 1'b0); @(posedge clk); #1; end
        send_one(4'd9, MEM_ACC_INSTR, BASE + 12, got);
        chk("fl_after_value", got.value, 64'h00300193);

        // Backdoor write in the same cycle as a read of that word returns old data.
        n = int'(model_mem[5]);
        req_vld = 1; req = mk(4'd7, MEM_ACC_INSTR, BASE + 20);
        init_we = 1; init_addr = 10'd5; init_data = 32'hCAFE_F00D;
        @(posedge clk); #1;
        init_we = 0; req_vld = 0; model_mem[5] = 32'hCAFE_F00D;
        @(negedge clk); @(negedge clk);
        chk("bd_old_value", ans.value, 64'(n));
        repeat (3) @(posedge clk); #1;
        send_one(4'd8, MEM_ACC_INSTR, BASE + 20, got);
        chk("bd_new_value", got.value, 64'hCAFE_F00D);

        // LATENCY=1 instance: simultaneous handshakes keep one request in flight.
        d1_ans_rdy = 1; d1_req_vld = 1;
        for (int i = 0; i < 11; i++) d1_reqs[i] = mk(4'(i), MEM_ACC_INSTR, BASE + 64'(4 * (i % 4)));
        d1_req = d1_reqs[0];
        @(negedge clk); chk("d1_first_ready", d1_req_rdy, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1; d1_req = d1_reqs[i];
            @(negedge clk);
            chk("d1_both_ready", {d1_req_rdy, d1_ans_vld}, 2'b11);
            chk("d1_ans", d1_ans, model(d1_reqs[i-1]));
        end
        @(posedge clk); #1; d1_req_vld = 0;
        @(negedge clk); chk("d1_last", d1_ans, model(d1_reqs[10]));
        @(posedge clk); #1;
        @(negedge clk); chk("d1_idle", d1_ans_vld, 1'b0);
        @(posedge clk); #1;

        // Randomized traffic, backpressure and occasional flush.
        for (int c = 0; c < 400; c++) begin
            req_vld = 1'($urandom_range(0, 1));
            req     = rand_req();
            ans_rdy = ($urandom_range(0, 3) != 0);
            flush   = ($urandom_range(0, 49) == 0);
            @(posedge clk); #1;
        end
        flush = 0; req_vld = 0; ans_rdy = 1;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
        chk("rand_drain", exp_q.size(), 0);
        @(negedge clk); chk("rand_idle", ans_vld, 1'b0);
        @(posedge clk); #1;

        // Asynchronous reset while the FIFO holds two answers.
        ans_rdy = 0; req_vld = 1; req = mk(4'd5, MEM_ACC_INSTR, BASE);
        @(posedge clk); #1; req = mk(4'd6, MEM_ACC_INSTR, BASE + 4);
        @(posedge clk); #1; req_vld = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); chk("rst_fifo_full", {ans_vld, req_rdy}, 2'b10);
        @(posedge clk); #3; rst_n = 0;
        #1; chk("rst_async_valid", ans_vld, 1'b0);
        @(posedge clk); @(posedge clk); #1; rst_n = 1;
        @(negedge clk);
        chk("rst_ready", req_rdy, 1'b1);
        chk("rst_valid", ans_vld, 1'b0);
        ans_rdy = 1;
        repeat (4) begin @(posedge clk); #1; @(negedge clk); chk("rst_no_stale", ans_vld, 1'b0); end
        @(posedge clk); #1;
        send_one(4'd10, MEM_ACC_INSTR, BASE + 12, got);
        chk("rst_preserved", got.value, 64'h00300193);
        send_one(4'd11, MEM_ACC_INSTR, BASE + 4 * 500, got);
        chk("rst_preserved_500", got.value, 64'(model_mem[500]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
